mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; SHALL be 32 or 64.
REQ-002 Parameter DEPTH_LOG2, default 11, log2 of RAM depth in DATA_W words.
REQ-003 Parameter REG_W, default 5, register-address width.
REQ-004 Parameter WB_W, default 2, writeback-control width.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 in_valid  in  1  upstream holds a valid request.
REQ-008 in_ready  out  1  stage accepts the request this cycle.
REQ-009 wbi  in  WB_W  writeback control, passed through.
REQ-010 regaddr  in  REG_W  destination register, passed through.
REQ-011 M  in  1  store enable; 0 means load or pass-through.
REQ-012 size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64).
REQ-013 sext  in  1  sign-extend load data (1) or zero-extend (0).
REQ-014 dataaddr  in  32  byte address (ALU result).
REQ-015 data  in  DATA_W  store data, right-aligned.
REQ-016 out_valid  out  1  result registers hold a valid result.
REQ-017 out_ready  in  1  downstream consumes the result.
REQ-018 wbo  out  WB_W  registered wbi.
REQ-019 regaddrout  out  REG_W  registered regaddr.
REQ-020 datafromimm  out  32  registered dataaddr.
REQ-021 datafrommem  out  DATA_W  aligned, extended load data.
REQ-022 misalign  out  1  registered misalignment flag for the result.

Function
REQ-023 Handshake: a request transfers when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-024 Latency: a request accepted at edge N SHALL have its result valid from edge N+1 (one cycle).
REQ-025 out_valid SHALL set on transfer and clear when out_ready && !transfer; a simultaneous consume and transfer keeps it at 1.
REQ-026 While out_valid && !out_ready, all outputs, including datafrommem, SHALL hold stable, and the RAM SHALL be neither read nor written.
REQ-027 Word index = dataaddr[DEPTH_LOG2+L-1 : L], with L = log2(DATA_W/8); higher address bits are ignored and the index wraps modulo the depth.
REQ-028 Alignment: an access is misaligned when its byte offset is not a multiple of its size in bytes; dword with DATA_W=32 counts as misaligned.
REQ-029 Store: M=1 on transfer with a legal alignment SHALL write only the addressed byte lanes, using data[8*2^size-1:0] replicated to the lanes; all other bytes are unchanged.
REQ-030 A misaligned store SHALL NOT write, and SHALL return misalign=1.
REQ-031 Load: the RAM read is performed on every transfer; datafrommem = the selected lanes shifted to bit 0, then extended per the registered sext and size.
REQ-032 A misaligned access SHALL return datafrommem=0.
REQ-033 A store result SHALL return the pre-write RAM contents on datafrommem (read-first).
REQ-034 Back-to-back store then load to the same word SHALL return the newly written data on the load.

Reset
REQ-035 While rst_n=0 at a posedge: out_valid, wbo, regaddrout, datafromimm, misalign and the registered size/offset/sext SHALL become 0, and datafrommem SHALL read 0.
REQ-036 Reset SHALL NOT clear RAM contents; a store accepted on the edge before reset asserts remains written.
REQ-037 During reset in_ready SHALL be 0, and no RAM write SHALL occur.

Structure
REQ-038 Package mem_pkg SHALL hold the size encodings (SZ_BYTE..SZ_DWORD) and a function returning the byte mask for a given size and offset.
REQ-039 One sub-module sp_bram: single-port, read-first, per-byte write enable, one-cycle read latency, parametrised width and depth.
REQ-040 Lane selection, extension and handshake logic reside in mem_stage.

Verification
REQ-041 Store word 0xDEADBEEF to 0x10, then load word from 0x10 -> datafrommem=0xDEADBEEF one cycle after acceptance.
REQ-042 Store byte 0x80 to 0x13, then load byte with sext=1 -> 0xFFFFFF80; with sext=0 -> 0x00000080; the other bytes of word 0x10 are unchanged.
REQ-043 Store half to 0x11 -> misalign=1, RAM unchanged, datafrommem=0.
REQ-044 Load result with out_ready held 0 for 3 cycles -> in_ready=0, outputs stable, and the next request is accepted on the cycle out_ready rises.
REQ-045 Assert rst_n=0 with out_valid=1 -> out_valid=0 after the edge, and a prior store is still readable after reset.
REQ-046 DATA_W=64, dword store 0x0123456789ABCDEF to 0x8, then load -> the same value; a dword access to 0x4 -> misalign=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and byte-lane helpers for the memory stage.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  // Lanes touched by an access of the given size starting at byte offset off.
  function automatic logic [7:0] byte_mask(input logic [1:0] sz, input logic [2:0] off);
    logic [7:0] m;
    case (sz)
      SZ_BYTE:  m = 8'h01;
      SZ_HALF:  m = 8'h03;
      SZ_WORD:  m = 8'h0F;
      SZ_DWORD: m = 8'hFF;
      default:  m = 8'h00;
    endcase
    return m << off;
  endfunction

  // Offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    logic [2:0] m;
    case (sz)
      SZ_BYTE:  m = 3'b000;
      SZ_HALF:  m = 3'b001;
      SZ_WORD:  m = 3'b011;
      SZ_DWORD: m = 3'b111;
      default:  m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sp_bram.sv
// Single-port block RAM: read-first, byte write enables, one-cycle read latency.
module sp_bram #(
  parameter int W          = 32,
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [W/8-1:0]        we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [W-1:0]          wdata,
  output logic [W-1:0]          rdata
);

  logic [W-1:0] mem_r [0:(1<<DEPTH_LOG2)-1];

  // Read returns the old word; enabled lanes are updated on the same edge.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem_r[addr];
      for (int i = 0; i < W/8; i++) begin
        if (we[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: valid/ready handshake, byte-addressed load/store
// into a local RAM, lane alignment and sign/zero extension of load data.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 11,
  parameter int REG_W      = 5,
  parameter int WB_W       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   wbi,
  input  logic [REG_W-1:0]  regaddr,
  input  logic              M,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       dataaddr,
  input  logic [DATA_W-1:0] data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wbo,
  output logic [REG_W-1:0]  regaddrout,
  output logic [31:0]       datafromimm,
  output logic [DATA_W-1:0] datafrommem,
  output logic              misalign
);

  localparam int NB = DATA_W / 8;
  localparam int L  = $clog2(NB);

  logic                  xfer_s;
  logic                  mis_s;
  logic [2:0]            off_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic [NB-1:0]         we_s;
  logic [DATA_W-1:0]     wdata_s;
  logic [DATA_W-1:0]     rdata_s;
  logic [DATA_W-1:0]     shifted_s;
  logic [DATA_W-1:0]     keep_s;
  logic [DATA_W-1:0]     ext_s;
  logic                  sign_s;
  logic [1:0]            size_r;
  logic [2:0]            off_r;
  logic                  sext_r;

  assign in_ready = rst_n && (!out_valid || out_ready);
  assign xfer_s   = in_valid && in_ready;
  assign off_s    = 3'(dataaddr[L-1:0]);
  assign idx_s    = dataaddr[DEPTH_LOG2+L-1:L];
  assign mis_s    = ((size == SZ_DWORD) && (DATA_W == 32)) ||
                    ((off_s & align_mask(size)) != 3'd0);

  // Replicate the right-aligned store operand across every lane and enable only the addressed ones.
  always_comb begin
    wdata_s = {DATA_W{1'b0}};
    for (int i = 0; i < NB; i++) begin
      case (size)
        SZ_BYTE: wdata_s[8*i +: 8] = data[7:0];
        SZ_HALF: wdata_s[8*i +: 8] = data[8*(i%2) +: 8];
        SZ_WORD: wdata_s[8*i +: 8] = data[8*(i%4) +: 8];
        default: wdata_s[8*i +: 8] = data[8*(i%8) +: 8];
      endcase
    end
    we_s = (xfer_s && M && !mis_s) ? NB'(byte_mask(size, off_s)) : {NB{1'b0}};
  end

  sp_bram #(
    .W          (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .en    (xfer_s),
    .we    (we_s),
    .addr  (idx_s),
    .wdata (wdata_s),
    .rdata (rdata_s)
  );

  // Bring the selected lanes down to bit 0 and extend them to the full width.
  always_comb begin
    shifted_s = rdata_s >> {off_r, 3'b000};
    case (size_r)
      SZ_BYTE: begin
        keep_s = {{(DATA_W-8){1'b0}}, 8'hFF};
        sign_s = shifted_s[7];
      end
      SZ_HALF: begin
        keep_s = {{(DATA_W-16){1'b0}}, 16'hFFFF};
        sign_s = shifted_s[15];
      end
      SZ_WORD: begin
        keep_s = {DATA_W{1'b1}} >> (DATA_W - 32);
        sign_s = shifted_s[31];
      end
      default: begin
        keep_s = {DATA_W{1'b1}};
        sign_s = 1'b0;
      end
    endcase
    ext_s = (shifted_s & keep_s) | ((sext_r && sign_s) ? ~keep_s : {DATA_W{1'b0}});
  end

  // RAM output is held while stalled, so the aligned result stays stable too.
  assign datafrommem = (out_valid && !misalign) ? ext_s : {DATA_W{1'b0}};

  // Result registers capture on transfer and hold while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      wbo         <= {WB_W{1'b0}};
      regaddrout  <= {REG_W{1'b0}};
      datafromimm <= 32'd0;
      misalign    <= 1'b0;
      size_r      <= 2'd0;
      off_r       <= 3'd0;
      sext_r      <= 1'b0;
    end else if (xfer_s) begin
      out_valid   <= 1'b1;
      wbo         <= wbi;
      regaddrout  <= regaddr;
      datafromimm <= dataaddr;
      misalign    <= mis_s;
      size_r      <= size;
      off_r       <= off_s;
      sext_r      <= sext;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule
